mem_access_sequencer: RTL

- Sits between the datapath's memory-stage signals (MemRW, RWType from the control unit; address from the ALU; store data from rs2) and a word-wide, byte-enabled data bus with a req/ack handshake.
- Converts each load/store into one or two aligned bus beats.
- Generates byte enables, aligns store data, and extracts plus sign- or zero-extends load data.
- Stalls the datapath until the access completes.

---
 rtl/mem_access_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Bridges the datapath's memory stage to a word-wide, byte-enabled bus with
// a req/ack handshake. Each load or store becomes one or two aligned beats.
// Store data is steered onto its byte lanes, and load data is extracted and
// sign- or zero-extended. The datapath is stalled until the access finishes.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   cmd_valid    memory instruction present; held by the datapath until done
//   MemRW        1 = store, 0 = load
//   RWType       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata  byte address and right-justified store data
//   stall        combinational; high while cmd_valid and the access is not in DONE
//   done, fault  one-cycle completion pulse, plus the error flag that goes with it
//   rdata        extended load result, meaningful while done on a load
//   bus_*        registered beat request towards memory; bus_ack/bus_rdata back
module mem_access_sequencer #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        MemRW,
    input  logic [2:0]  RWType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  rw_type_q, rw_type_d;
    logic [1:0]  off_q, off_d;
    logic        two_beat_q, two_beat_d;
    logic [3:0]  be_hi_q, be_hi_d;
    logic [31:0] wdata_hi_q, wdata_hi_d;
    logic [31:0] lo_q, lo_d;

    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic [1:0]  cmd_off;
    logic [3:0]  cmd_mask;
    logic [7:0]  cmd_be8;
    logic [63:0] cmd_wd64;
    logic        cmd_illegal;
    logic        cmd_misaligned;
    logic [63:0] beat_pair;
    logic [31:0] ext_word;
    logic [31:0] load_result;
    logic        complete;

    // Decode the live command inputs. The byte mask and the store data are
    // shifted across an 8-lane / 64-bit window so that the upper half
    // directly becomes the second beat whenever the access spills over a
    // word boundary. Unsigned types are meaningless for stores, so those
    // codes fault as well.
    always_comb begin
        cmd_off  = addr[1:0];
        case (RWType[1:0])
            2'b00:   cmd_mask = 4'b0001;
            2'b01:   cmd_mask = 4'b0011;
            default: cmd_mask = 4'b1111;
        endcase
        cmd_be8        = {4'b0000, cmd_mask} << cmd_off;
        cmd_wd64       = {32'h0, wdata} << {cmd_off, 3'b000};
        cmd_illegal    = (RWType == 3'b011) || (RWType[2:1] == 2'b11) || (MemRW && RWType[2]);
        cmd_misaligned = ((RWType[1:0] == 2'b01) && cmd_off[0]) ||
                         ((RWType[1:0] == 2'b10) && (cmd_off != 2'b00));
    end

    // Build the load result from the word(s) returned by the bus. On the
    // final ack the last word is still only on bus_rdata, so it is used
    // directly instead of waiting for a capture register.
    always_comb begin
        beat_pair = (state_q == BEAT1) ? {bus_rdata, lo_q} : {32'h0, bus_rdata};
        ext_word  = 32'(beat_pair >> {off_q, 3'b000});
        case (rw_type_q)
            3'b000:  load_result = {{24{ext_word[7]}}, ext_word[7:0]};
            3'b001:  load_result = {{16{ext_word[15]}}, ext_word[15:0]};
            3'b100:  load_result = {24'h0, ext_word[7:0]};
            3'b101:  load_result = {16'h0, ext_word[15:0]};
            default: load_result = ext_word;
        endcase
    end

    // Sequencer next-state and registered-output logic. The bus fields for
    // the next beat are prepared one edge early so everything presented to
    // the bus comes straight from flops. Finishing a beat sequence is
    // funnelled through 'complete' so both beat states share one exit path.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        rw_type_d   = rw_type_q;
        off_d       = off_q;
        two_beat_d  = two_beat_q;
        be_hi_d     = be_hi_q;
        wdata_hi_d  = wdata_hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    is_store_d = MemRW;
                    rw_type_d  = RWType;
                    off_d      = cmd_off;
                    two_beat_d = |cmd_be8[7:4];
                    be_hi_d    = cmd_be8[7:4];
                    wdata_hi_d = cmd_wd64[63:32];
                    lo_d       = 32'h0;
                    if (cmd_illegal || (cmd_misaligned && !ALLOW_MISALIGNED)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        state_d     = BEAT0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemRW;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = cmd_be8[3:0];
                        bus_wdata_d = cmd_wd64[31:0];
                    end
                end
            end
            BEAT0: begin
                if (bus_ack) begin
                    lo_d = bus_rdata;
                    if (two_beat_q) begin
                        state_d     = BEAT1;
                        bus_addr_d  = bus_addr_q + 32'd4;
                        bus_be_d    = be_hi_q;
                        bus_wdata_d = wdata_hi_q;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (bus_ack) begin
                    complete = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            state_d     = DONE;
            done_d      = 1'b1;
            rdata_d     = is_store_q ? 32'h0 : load_result;
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_be_d    = 4'b0000;
            bus_wdata_d = 32'h0;
        end
    end

    // State and output registers. Reset clears everything, which also drops
    // an in-flight request; a late ack then lands in IDLE and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            rw_type_q   <= 3'b000;
            off_q       <= 2'b00;
            two_beat_q  <= 1'b0;
            be_hi_q     <= 4'b0000;
            wdata_hi_q  <= 32'h0;
            lo_q        <= 32'h0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            rw_type_q   <= rw_type_d;
            off_q       <= off_d;
            two_beat_q  <= two_beat_d;
            be_hi_q     <= be_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign stall     = cmd_valid && (state_q != DONE);
    assign done      = done_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
